// File: rtl/serial_adder_seq.sv
`default_nettype none
// ============================================================================
// Module     : serial_adder_seq
// Description: Bit-serial ripple adder with a start/busy/done handshake. It adds
//              LSB first, one bit per clock, using a single full-adder slice
//              and a carry flip-flop. Defining SERIAL_ADD_OVF_EN adds the ovf
//              output, which reports two's-complement signed overflow.
// Revision   : 1.0 - initial release
// ============================================================================
module serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int             CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic slice_s;
  logic slice_c;

  // The full-adder slice is built from two half-adder stages.
  logic ha0_s, ha0_c, ha1_c;
  assign ha0_s   = a_sr_q[0] ^ b_sr_q[0];
  assign ha0_c   = a_sr_q[0] & b_sr_q[0];
  assign slice_s = ha0_s ^ carry_q;
  assign ha1_c   = ha0_s & carry_q;
  assign slice_c = ha0_c | ha1_c;

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        sum_d   = {slice_s, sum_q[WIDTH-1:1]};
        carry_d = slice_c;
        a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // carry_q is the carry into the MSB slice at this point.
          cout_d  = slice_c;
          ovf_d   = carry_q ^ slice_c;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

`ifdef SERIAL_ADD_OVF_EN
  assign ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_seq.sv
`default_nettype none
// ============================================================================
// Module     : tb_serial_adder_seq
// Description: Directed self-checking bench for serial_adder_seq (WIDTH=8).
//              It also covers the ovf output when SERIAL_ADD_OVF_EN is defined.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_serial_adder_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
`ifdef SERIAL_ADD_OVF_EN
  logic       ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int lat;
  int bcnt;

  serial_adder_seq #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
`ifdef SERIAL_ADD_OVF_EN
    .ovf   (ovf),
`endif
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive operands and make start high for exactly one rising edge.
  task automatic accept(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    @(negedge clk);
    a = av; b = bv; cin = cv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count the negedges until done is seen (bounded); lat = negedge index of done.
  task automatic wait_done(output int l, output int bc);
    l = 0; bc = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      l++;
      if (busy && done) check("busy_and_done", 32'd1, 32'd0);
      if (done) break;
      if (busy) bc++;
    end
  endtask

  task automatic run_add(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic cv, input logic [7:0] es, input logic ec);
    accept(av, bv, cv);
    wait_done(lat, bcnt);
    check({tag, "_lat"}, lat, 9);
    check({tag, "_busycnt"}, bcnt, 8);
    check({tag, "_sum"}, {24'd0, sum}, {24'd0, es});
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #3;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", {24'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic addition and carry/wrap cases
    run_add("basic", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
    @(negedge clk);
    check("done_pulse_once", {31'd0, done}, 32'd0);
    run_add("wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_add("allones_cin", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // A start pulse while busy must be ignored
    accept(8'h12, 8'h34, 1'b0);
    repeat (3) @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcnt);
    check("busystart_lat", lat + 4, 9);
    check("busystart_sum", {24'd0, sum}, 32'h46);
    check("busystart_cout", {31'd0, cout}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_sum", {24'd0, sum}, 32'h46);
      check("hold_busy", {31'd0, busy}, 32'd0);
    end

    // Back-to-back: start held high so DONE accepts the next operation
    @(negedge clk);
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 a = 8'h80; b = 8'h80;
    wait_done(lat, bcnt);
    check("b2b_first_lat", lat, 9);
    check("b2b_first_sum", {24'd0, sum}, 32'h03);
    check("b2b_first_cout", {31'd0, cout}, 32'd0);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("b2b_reaccept_busy", {31'd0, busy}, 32'd1);
    wait_done(lat, bcnt);
    check("b2b_second_lat", lat + 1, 9);
    check("b2b_second_sum", {24'd0, sum}, 32'h00);
    check("b2b_second_cout", {31'd0, cout}, 32'd1);

    // Asynchronous reset in the middle of an operation
    accept(8'h33, 8'h44, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_sum", {24'd0, sum}, 32'd0);
    check("arst_cout", {31'd0, cout}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) rst_n = 1'b1;
      check("arst_no_done", {31'd0, done}, 32'd0);
    end
    run_add("after_rst", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0);

`ifdef SERIAL_ADD_OVF_EN
    run_add("ovf_pos", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
    check("ovf_pos_ovf", {31'd0, ovf}, 32'd1);
    run_add("ovf_neg", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
    check("ovf_neg_ovf", {31'd0, ovf}, 32'd1);
    run_add("ovf_none", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    check("ovf_none_ovf", {31'd0, ovf}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
